// File: rtl/incr_fwd_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : incr_fwd_pkg
// Description : Shared constants and increment arithmetic for incr_fwd_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package incr_fwd_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Returns {ovf, result} packed into the low width+1 bits (width <= 32).
  function automatic logic [32:0] incr_sat(
    input logic [31:0] a,
    input logic [31:0] incr,
    input int          mode,
    input int          width
  );
    logic [32:0] mask;
    logic [32:0] sum;
    logic [32:0] res;
    logic        ovf;
    mask = (33'd1 << width) - 33'd1;
    sum  = ({1'b0, a} & mask) + ({1'b0, incr} & mask);
    ovf  = (sum >> width) != 33'd0;
    res  = sum & mask;
    if (mode == MODE_SAT && ovf) begin
      res = mask;
    end
    return res | ({32'd0, ovf} << width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/incr_fwd_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : incr_fwd_stage
// Description : One elastic register stage holding a valid bit and W data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module incr_fwd_stage #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         drain,
  output logic         load,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign load  = !r_valid || drain;
  assign valid = r_valid;
  assign data  = r_data;

  // Data only moves with a valid item so an emptied stage keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= up_valid;
      if (up_valid) begin
        r_data <= up_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/incr_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : incr_fwd_pipe
// Description : Elastic DEPTH-stage pipeline computing b = c = a + INCR.
// Revision    : 1.0 - initial release
// ============================================================================
module incr_fwd_pipe
  import incr_fwd_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int INCR  = 1,
  parameter int MODE  = MODE_WRAP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH:0]   w_stage0;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] r_occ;

  // Arithmetic happens once; later stages only carry {ovf, result}.
  assign w_stage0 = (WIDTH+1)'(incr_sat(32'(a), 32'(INCR), MODE, WIDTH));

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic           w_up_valid;
    logic [WIDTH:0] w_up_data;
    logic           w_drain;
    logic           w_load;
    logic           w_valid;
    logic [WIDTH:0] w_data;

    if (k == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = w_stage0;
    end else begin : g_body
      assign w_up_valid = g_stage[k-1].w_valid;
      assign w_up_data  = g_stage[k-1].w_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign w_drain = w_valid && out_ready;
    end else begin : g_link
      assign w_drain = g_stage[k+1].w_load;
    end

    incr_fwd_stage #(
      .W(WIDTH + 1)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_valid(w_up_valid),
      .up_data (w_up_data),
      .drain   (w_drain),
      .load    (w_load),
      .valid   (w_valid),
      .data    (w_data)
    );
  end

  assign in_ready  = g_stage[0].w_load;
  assign out_valid = g_stage[DEPTH-1].w_valid;
  assign b         = g_stage[DEPTH-1].w_data[WIDTH-1:0];
  assign c         = g_stage[DEPTH-1].w_data[WIDTH-1:0];
  assign ovf       = g_stage[DEPTH-1].w_data[WIDTH];

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;

  a_b_equals_c : assert property (@(posedge clk) disable iff (!rst_n) b == c);

endmodule
`default_nettype wire
